// File: rtl/fdma_mem_responder.sv
// FDMA burst responder backed by an on-chip single-port RAM.
// Serves one write or read burst at a time, one beat per clock.
module fdma_mem_responder #(
    parameter  int AXI_DATA_WIDTH = 128,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int MEM_DEPTH      = 4096,
    localparam int ADDR_LSB       = $clog2(AXI_DATA_WIDTH / 8),
    localparam int IDX_W          = $clog2(MEM_DEPTH)
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
    input  logic                      fdma_wareq,
    input  logic [15:0]               fdma_wsize,
    output logic                      fdma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
    output logic                      fdma_wvalid,
    input  logic                      fdma_wready,
    output logic                      fdma_wdone,
    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
    input  logic                      fdma_rareq,
    input  logic [15:0]               fdma_rsize,
    output logic                      fdma_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    output logic                      fdma_rvalid,
    input  logic                      fdma_rready,
    output logic                      fdma_rdone
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t                    state;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]          idx;
    logic [15:0]               size_q;
    logic [15:0]               cnt;
    logic [15:0]               issued;
    logic                      rd_prio;
    logic [AXI_DATA_WIDTH-1:0] skid_data;
    logic                      skid_valid;

    logic                      w_hs;
    logic                      r_hs;
    logic                      issue;
    logic                      last;
    logic                      grant_w;
    logic                      grant_r;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic                      unused_addr_bits;

    assign w_hs    = fdma_wvalid && fdma_wready;
    assign r_hs    = fdma_rvalid && fdma_rready;
    assign last    = cnt == size_q - 16'd1;
    assign rd_word = mem[idx];
    assign unused_addr_bits = ^{fdma_waddr, fdma_raddr};

    // A read may be issued only if the two-entry output buffer has room after this edge.
    assign issue = state == RD && issued < size_q
                   && !(fdma_rvalid && skid_valid && !fdma_rready);

    // Round-robin pointer moves only when both channels contend.
    assign grant_w = fdma_wareq && (!fdma_rareq || !rd_prio);
    assign grant_r = fdma_rareq && !grant_w;

    always_ff @(posedge ui_clk) begin
        if (!ui_rst && w_hs)
            mem[idx] <= fdma_wdata;
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state       <= IDLE;
            idx         <= '0;
            size_q      <= '0;
            cnt         <= '0;
            issued      <= '0;
            rd_prio     <= 1'b0;
            skid_data   <= '0;
            skid_valid  <= 1'b0;
            fdma_wbusy  <= 1'b0;
            fdma_wvalid <= 1'b0;
            fdma_wdone  <= 1'b0;
            fdma_rbusy  <= 1'b0;
            fdma_rvalid <= 1'b0;
            fdma_rdata  <= '0;
            fdma_rdone  <= 1'b0;
        end else begin
            fdma_wdone <= 1'b0;
            fdma_rdone <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt    <= '0;
                    issued <= '0;
                    if (grant_w) begin
                        state       <= WR;
                        idx         <= fdma_waddr[ADDR_LSB +: IDX_W];
                        size_q      <= fdma_wsize;
                        fdma_wbusy  <= 1'b1;
                        fdma_wvalid <= fdma_wsize != 16'd0;
                        fdma_wdone  <= fdma_wsize == 16'd0;
                        if (fdma_rareq)
                            rd_prio <= 1'b1;
                    end else if (grant_r) begin
                        state      <= RD;
                        idx        <= fdma_raddr[ADDR_LSB +: IDX_W];
                        size_q     <= fdma_rsize;
                        fdma_rbusy <= 1'b1;
                        fdma_rdone <= fdma_rsize == 16'd0;
                        if (fdma_wareq)
                            rd_prio <= 1'b0;
                    end
                end
                WR: begin
                    if (size_q == 16'd0) begin
                        state      <= IDLE;
                        fdma_wbusy <= 1'b0;
                    end else if (w_hs) begin
                        idx <= idx + 1'b1;
                        cnt <= cnt + 16'd1;
                        if (last) begin
                            state       <= IDLE;
                            fdma_wbusy  <= 1'b0;
                            fdma_wvalid <= 1'b0;
                            fdma_wdone  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue) begin
                        idx    <= idx + 1'b1;
                        issued <= issued + 16'd1;
                    end
                    if (r_hs)
                        cnt <= cnt + 16'd1;
                    // Output register is the buffer head, skid_data the second entry.
                    if (r_hs) begin
                        if (skid_valid) begin
                            fdma_rdata <= skid_data;
                            skid_valid <= issue;
                            if (issue)
                                skid_data <= rd_word;
                        end else if (issue) begin
                            fdma_rdata <= rd_word;
                        end else begin
                            fdma_rvalid <= 1'b0;
                        end
                    end else if (issue) begin
                        if (!fdma_rvalid) begin
                            fdma_rdata  <= rd_word;
                            fdma_rvalid <= 1'b1;
                        end else begin
                            skid_data  <= rd_word;
                            skid_valid <= 1'b1;
                        end
                    end
                    if (size_q == 16'd0) begin
                        state      <= IDLE;
                        fdma_rbusy <= 1'b0;
                    end else if (r_hs && last) begin
                        state       <= IDLE;
                        fdma_rbusy  <= 1'b0;
                        fdma_rvalid <= 1'b0;
                        skid_valid  <= 1'b0;
                        fdma_rdone  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
